// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data-memory responder with protocol policing
//
// Target end of the core's dmem request/response interface. One word-aligned
// request is accepted at a time, serviced from an internal word array after
// LATENCY cycles, and completed with a one-cycle o_dmem_resp pulse. One idle GAP
// cycle follows every response.
//
// Ports:
//   i_clk          clock, all state changes on the rising edge
//   i_rst          asynchronous active-low reset
//   i_dmem_addr    byte address, bits [1:0] ignored
//   i_dmem_rmask   byte read mask, nonzero = read request
//   i_dmem_wmask   byte write mask, nonzero = write request
//   i_dmem_wdata   lane-aligned write data
//   o_dmem_rdata   full read word, zero whenever o_dmem_resp is low
//   o_dmem_resp    one-cycle completion pulse
//   o_proto_err    sticky protocol / address error flag
//   o_txn_count    completed transactions, wraps at 16 bits
module dmem_responder #(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_dmem_addr,
    input  logic [3:0]  i_dmem_rmask,
    input  logic [3:0]  i_dmem_wmask,
    input  logic [31:0] i_dmem_wdata,
    output logic [31:0] o_dmem_rdata,
    output logic        o_dmem_resp,
    output logic        o_proto_err,
    output logic [15:0] o_txn_count
);

    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [29:0] r_idx;
    logic [3:0]  r_rmask;
    logic [3:0]  r_wmask;
    logic [31:0] r_wdata;
    logic [31:0] r_mem [0:MEM_WORDS-1];

    logic        w_req;
    logic        w_live_in_range;
    logic        w_in_range;
    logic        w_done;
    logic        w_we;
    logic        w_unstable;
    logic [31:0] w_mem_word;
    logic [1:0]  w_unused_addr_bits;

    assign w_unused_addr_bits = i_dmem_addr[1:0];

    assign w_req           = (i_dmem_rmask != 4'd0) || (i_dmem_wmask != 4'd0);
    // Index is compared unwrapped so aliases above the array are rejected.
    assign w_live_in_range = ({2'b00, i_dmem_addr[31:2]} < 32'(MEM_WORDS));
    assign w_in_range      = ({2'b00, r_idx} < 32'(MEM_WORDS));
    assign w_done          = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_we            = w_done && (r_wmask != 4'd0) && w_in_range;
    assign w_mem_word      = r_mem[r_idx[AW-1:0]];

    // Initiator must hold the request unchanged for the whole WAIT; wdata only
    // matters for writes, and withdrawing both masks is also a violation.
    assign w_unstable = (i_dmem_addr[31:2] != r_idx)
                     || (i_dmem_rmask != r_rmask)
                     || (i_dmem_wmask != r_wmask)
                     || ((r_wmask != 4'd0) && (i_dmem_wdata != r_wdata))
                     || !w_req;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_idx        <= 30'd0;
            r_rmask      <= 4'd0;
            r_wmask      <= 4'd0;
            r_wdata      <= 32'd0;
            o_dmem_resp  <= 1'b0;
            o_dmem_rdata <= 32'd0;
            o_proto_err  <= 1'b0;
            o_txn_count  <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    o_dmem_resp  <= 1'b0;
                    o_dmem_rdata <= 32'd0;
                    if (w_req) begin
                        r_idx   <= i_dmem_addr[31:2];
                        r_rmask <= i_dmem_rmask;
                        r_wmask <= i_dmem_wmask;
                        r_wdata <= i_dmem_wdata;
                        r_cnt   <= 4'(LATENCY - 1);
                        r_state <= S_WAIT;
                        // Mixed read/write (serviced as a write) or out-of-range index.
                        if (((i_dmem_rmask != 4'd0) && (i_dmem_wmask != 4'd0)) || !w_live_in_range)
                            o_proto_err <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (w_unstable)
                        o_proto_err <= 1'b1;
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        o_dmem_resp  <= 1'b1;
                        o_dmem_rdata <= ((r_wmask == 4'd0) && w_in_range) ? w_mem_word : 32'd0;
                        o_txn_count  <= o_txn_count + 16'd1;
                        r_state      <= S_GAP;
                    end
                end
                S_GAP: begin
                    o_dmem_resp  <= 1'b0;
                    o_dmem_rdata <= 32'd0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    o_dmem_resp  <= 1'b0;
                    o_dmem_rdata <= 32'd0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    // Array is not reset; the write commits on the same edge that raises resp.
    // A reset while in WAIT forces the state to IDLE, so no commit can follow.
    always_ff @(posedge i_clk) begin
        if (w_we) begin
            for (int i = 0; i < 4; i++) begin
                if (r_wmask[i])
                    r_mem[r_idx[AW-1:0]][8*i +: 8] <= r_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;

    localparam int MEM_WORDS = 1024;
    localparam int LAT       = 3;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        resp;
    logic        perr;
    logic [15:0] txn;

    int vectors;
    int miscompares;

    logic [31:0] model [0:MEM_WORDS-1];
    int          exp_txn;
    logic        exp_perr;

    dmem_responder #(.MEM_WORDS(MEM_WORDS), .LATENCY(LAT)) dut (
        .i_clk        (clk),
        .i_rst        (rst_n),
        .i_dmem_addr  (addr),
        .i_dmem_rmask (rmask),
        .i_dmem_wmask (wmask),
        .i_dmem_wdata (wdata),
        .o_dmem_rdata (rdata),
        .o_dmem_resp  (resp),
        .o_proto_err  (perr),
        .o_txn_count  (txn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reset held across two falling edges; released on a falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        rmask = 4'd0;
        wmask = 4'd0;
        @(negedge clk);
        @(negedge clk);
        exp_txn  = 0;
        exp_perr = 1'b0;
        chk("rst_resp", {31'd0, resp}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_perr", {31'd0, perr}, 32'd0);
        chk("rst_txn", {16'd0, txn}, 32'd0);
        rst_n = 1'b1;
    endtask

    // Called at a falling edge; request accepted on the next rising edge.
    // Response expected in the (LAT+1)-th cycle after acceptance, then a quiet cycle.
    task automatic do_txn(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                          input logic [31:0] wd, input bit drop, input bit chg, input string tag);
        int          idx;
        logic [31:0] exp_rd;
        logic [31:0] w;
        bit          err;
        idx    = int'(a >> 2);
        err    = ((rm != 0) && (wm != 0)) || (idx >= MEM_WORDS) || chg;
        exp_rd = 32'd0;
        if ((wm == 0) && (idx < MEM_WORDS))
            exp_rd = model[idx];
        addr  = a;
        rmask = rm;
        wmask = wm;
        wdata = wd;
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            if (k == 1 && chg)
                addr = a + 32'd4;
            if (k <= LAT) begin
                chk({tag, "_noresp"}, {31'd0, resp}, 32'd0);
                chk({tag, "_idle_rdata"}, rdata, 32'd0);
            end else begin
                chk({tag, "_resp"}, {31'd0, resp}, 32'd1);
                chk({tag, "_rdata"}, rdata, exp_rd);
            end
        end
        if ((wm != 0) && (idx < MEM_WORDS)) begin
            w = model[idx];
            for (int b = 0; b < 4; b++)
                if (wm[b]) w[8*b +: 8] = wd[8*b +: 8];
            model[idx] = w;
        end
        exp_txn = (exp_txn + 1) % 65536;
        if (err) exp_perr = 1'b1;
        chk({tag, "_txn"}, {16'd0, txn}, 32'(exp_txn));
        chk({tag, "_perr"}, {31'd0, perr}, {31'd0, exp_perr});
        if (drop) begin
            rmask = 4'd0;
            wmask = 4'd0;
        end
        @(negedge clk);
        chk({tag, "_pulse_end"}, {31'd0, resp}, 32'd0);
        chk({tag, "_post_rdata"}, rdata, 32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [3:0]  rmsk;
        vectors     = 0;
        miscompares = 0;
        exp_txn     = 0;
        exp_perr    = 1'b0;
        rst_n = 1'b0;
        addr  = 32'd0;
        rmask = 4'd0;
        wmask = 4'd0;
        wdata = 32'd0;

        do_reset();

        do_txn(32'h100, 4'h0, 4'hF, 32'hDEADBEEF, 1, 0, "wr100");
        do_txn(32'h100, 4'h1, 4'h0, 32'h0, 1, 0, "rd100");
        do_txn(32'h102, 4'h0, 4'b1100, 32'h1234_0000, 1, 0, "wr102_hi");
        do_txn(32'h100, 4'hF, 4'h0, 32'h0, 1, 0, "rd100_merge");
        chk("merge_value", model[32'h100 >> 2], 32'h1234BEEF);
        do_txn(32'h0, 4'h0, 4'hF, 32'hC0FFEE00, 1, 0, "wr000");

        // Request held through the GAP cycle: back-to-back at LAT+2 spacing.
        do_txn(32'h104, 4'h0, 4'hF, 32'hA5A5_5A5A, 0, 0, "hold_a");
        do_txn(32'h104, 4'h0, 4'hF, 32'hA5A5_5A5A, 1, 0, "hold_b");
        do_txn(32'h104, 4'h2, 4'h0, 32'h0, 1, 0, "hold_rd");

        // Randomized traffic over a small window of pre-initialised words.
        for (int i = 0; i < 16; i++)
            do_txn(32'h140 + 32'(4 * i), 4'h0, 4'hF, $urandom, 1, 0, "fill");
        for (int i = 0; i < 40; i++) begin
            ra   = 32'h140 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            rmsk = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 1) == 1)
                do_txn(ra, 4'h0, rmsk, $urandom, 1, 0, "rnd_wr");
            else
                do_txn(ra, rmsk, 4'h0, 32'h0, 1, 0, "rnd_rd");
        end

        // Reset one cycle into WAIT of a write: aborted, no commit, no late resp.
        do_txn(32'h200, 4'h0, 4'hF, 32'h0BADF00D, 1, 0, "wr200");
        addr  = 32'h200;
        wmask = 4'hF;
        wdata = 32'h5555_5555;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wmask = 4'd0;
        exp_txn  = 0;
        exp_perr = 1'b0;
        for (int k = 0; k < LAT + 3; k++) begin
            @(negedge clk);
            chk("abort_noresp", {31'd0, resp}, 32'd0);
        end
        chk("abort_txn", {16'd0, txn}, 32'd0);
        chk("abort_perr", {31'd0, perr}, 32'd0);
        do_txn(32'h200, 4'hF, 4'h0, 32'h0, 1, 0, "rd200_after_abort");

        // Protocol errors, each cleared only by reset.
        do_txn(32'h100, 4'hF, 4'h1, 32'h0000_0077, 1, 0, "both_masks");
        do_reset();
        do_txn(32'h100, 4'hF, 4'h0, 32'h0, 1, 0, "rd_after_both");
        do_txn(32'h1000, 4'h0, 4'hF, 32'hFFFF_FFFF, 1, 0, "oor_wr");
        do_txn(32'h1000, 4'hF, 4'h0, 32'h0, 1, 0, "oor_rd");
        do_reset();
        do_txn(32'h0, 4'hF, 4'h0, 32'h0, 1, 0, "rd0_nowrap");
        do_txn(32'h100, 4'hF, 4'h0, 32'h0, 1, 1, "addr_change");
        do_txn(32'h104, 4'hF, 4'h0, 32'h0, 1, 0, "perr_sticky");
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Synthesizable data-memory responder: the target end of the core's dmem request/response interface, whose initiator is the load/store queue.
- Accepts one word-aligned request at a time, carrying a byte read mask or a byte write mask.
- Services the request from an internal word array after a fixed latency and pulses dmem_resp for one cycle.
- Used as the data memory in core-level simulation and FPGA builds; also polices the initiator's protocol.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words in the array; power of two.
- LATENCY, 3, cycles from request acceptance to dmem_resp; legal range 1..15.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- dmem_addr  input  32  byte address; bits [1:0] ignored.
- dmem_rmask  input  4  byte read mask; nonzero = read request.
- dmem_wmask  input  4  byte write mask; nonzero = write request.
- dmem_wdata  input  32  write data, lane-aligned.
- dmem_rdata  output  32  read data, full word, valid only while dmem_resp=1.
- dmem_resp  output  1  one-cycle completion pulse.
- proto_err  output  1  sticky protocol/address error flag.
- txn_count  output  16  completed transactions, wraps at 16'hFFFF->0.

Behaviour:
- Reset (rst=0, async): state=IDLE; dmem_resp=0, dmem_rdata=0, proto_err=0, txn_count=0, latency counter=0.
  - Array contents are not reset.
  - An in-flight request is aborted: no write commit, no resp after release.
- FSM states: IDLE, WAIT, GAP.
- IDLE:
  - A request is present when rmask!=0 or wmask!=0.
  - On such an edge: latch addr[31:2], rmask, wmask, wdata; load counter=LATENCY-1; go to WAIT.
- WAIT:
  - While counter!=0: decrement.
  - When counter==0 at an edge, perform the operation, drive dmem_resp=1 and dmem_rdata for the following cycle, increment txn_count, and go to GAP.
  - Net effect: request sampled at edge E0 gives resp high in the cycle after edge E_LATENCY.
- GAP:
  - Exactly one cycle; dmem_resp=0, dmem_rdata=0.
  - Inputs are ignored (the initiator drops its masks in this cycle); return to IDLE.
  - Minimum request-to-request spacing is therefore LATENCY+2 cycles.
- Read:
  - dmem_rdata = full array word at the latched index; rmask does not zero any lanes.
  - The initiator performs byte/half extraction and sign extension.
- Write:
  - Only byte lanes with wmask[i]=1 are updated from wdata[8i+7:8i], at the same edge that raises dmem_resp.
  - Other lanes are preserved.
  - dmem_rdata=0 during a write resp.
- Both rmask and wmask nonzero at acceptance: treated as a write; rdata=0; proto_err set.
- Out of range (latched addr[31:2] >= MEM_WORDS):
  - resp still given, rdata=0, no write, proto_err set.
  - Index is not wrapped.
- Stability rule:
  - In WAIT, any difference between live addr[31:2], rmask, wmask, wdata and the latched values sets proto_err.
  - Differences in wdata are checked only when the latched wmask!=0.
  - The latched values are always used.
  - All masks zero in WAIT is also a violation (request withdrawn); the transaction still completes.
- proto_err clears only on reset.
- dmem_rdata is 0 in every cycle where dmem_resp=0.
- Read-after-write to the same word, with the second request accepted after the first resp, returns the new data.

Test Plan:
- LATENCY=3, reset release, write addr=0x100 wmask=4'hF wdata=0xDEADBEEF held until resp -> resp high exactly in 4th cycle after acceptance edge, one cycle wide; txn_count=1; proto_err=0.
- Read addr=0x100 rmask=4'h1 -> rdata=0xDEADBEEF during the resp cycle only, 0 otherwise; txn_count=2.
- Write addr=0x102 wmask=4'b1100 wdata=0x1234_0000, then read addr=0x100 -> rdata=0x1234BEEF.
- Request held through the GAP cycle after resp -> no second acceptance in GAP; re-accepted the next cycle (IDLE); spacing = LATENCY+2.
- Protocol errors, each -> resp still issued and proto_err=1 until reset:
  - rmask=4'hF with wmask=4'h1;
  - addr=0x1000 (index 1024, MEM_WORDS=1024);
  - addr changed from 0x100 to 0x104 mid-WAIT.
- Assert rst low one cycle into WAIT of a write to 0x200 wdata=0x5555_5555; after release read 0x200 -> no resp until the new request; read returns the prior value, not 0x55555555; txn_count=0 after reset.
